icache_fill_ctrl: RTL
=====================

ICACHE_FILL_CTRL -- requirements
Module: icache_fill_ctrl

Interface
REQ-001 The block SHALL have no parameters: 2 ways, 64 sets, 8 x 16-bit words per block, and 16-bit byte addresses are fixed.
REQ-002 The block SHALL be clocked by `clk` (input, 1): a single rising-edge clock.
REQ-003 The block SHALL have reset `rst` (input, 1): asynchronous, active-low.
REQ-004 `miss` (input, 1): instruction fetch missed; qualifies `miss_addr`.
REQ-005 `miss_addr` (input, 16): byte address, decoded as tag [15:10], set [9:4], word [3:1].
REQ-006 `tag_out0` and `tag_out1` (input, 8 each): metadata read back for the addressed set, formatted {LRU, valid, tag[5:0]}.
REQ-007 `mem_data_out` (input, 16): read data returned by memory.
REQ-008 `mem_data_valid` (input, 1): `mem_data_out` is valid this cycle; returns are in issue order.
REQ-009 `mem_addr` (output, 16): word-aligned read address sent to memory.
REQ-010 `mem_enable` (output, 1): read issue strobe, one request per cycle.
REQ-011 `data_wrt_en` and `tag_wrt_en` (output, 1 each): cache array write strobes.
REQ-012 `way0` and `way1` (output, 1 each): way selects, one-hot or both zero.
REQ-013 `Tag_In` (output, 8): metadata write value.
REQ-014 `Data_In` (output, 16): data write value.
REQ-015 `blk_en` (output, 64): one-hot set select.
REQ-016 `word_enable` (output, 8): one-hot word select.
REQ-017 `busy` (output, 1): high in every state except IDLE; used to stall fetch.
REQ-018 `fill_done` (output, 1): one-cycle pulse when the fill completes.

Function
REQ-019 The FSM states SHALL be IDLE, ALLOC, FILL, TAG_V, TAG_O.
- IDLE->ALLOC on `miss`.
- ALLOC->FILL after exactly 1 cycle.
- FILL->TAG_V when 8 words have been received.
- TAG_V->TAG_O->IDLE, 1 cycle each.
REQ-020 In IDLE, on `miss` the block SHALL latch `miss_addr`; `miss` SHALL be ignored in every other state.
REQ-021 In ALLOC, the block SHALL drive `blk_en` = one-hot(set) and choose the victim from `tag_out0`/`tag_out1`:
- way0 if way0 is invalid;
- else way1 if way1 is invalid;
- else way0 if `tag_out0`[7] = 1;
- else way1.
It SHALL latch the non-victim metadata.
REQ-022 In FILL, the block SHALL issue 8 reads on consecutive cycles, starting at the start word and incrementing mod 8: `mem_enable` = 1, `mem_addr` = {tag, set, word, 1'b0}.
REQ-023 The issue counter SHALL saturate at 8; after it does, `mem_enable` = 0.
REQ-024 Each `mem_data_valid` in FILL SHALL produce, in the same cycle:
- `data_wrt_en` = 1 with the victim way selected;
- `word_enable` = one-hot(receive index);
- `Data_In` = `mem_data_out`.
The receive index starts at the start word and wraps mod 8.
REQ-025 `mem_data_valid` outside FILL, or after 8 words have been received, SHALL be ignored.
REQ-026 Issue and receive SHALL overlap: a 4-cycle memory gives FILL = 12 cycles, and `miss` to `fill_done` = 15 cycles.
REQ-027 In TAG_V, the block SHALL write the victim way: `tag_wrt_en` = 1, `Tag_In` = {0, 1, tag}.
REQ-028 In TAG_O, the block SHALL write the other way: `tag_wrt_en` = 1, `Tag_In` = {1, latched valid, latched tag}, and `fill_done` = 1.
REQ-029 `blk_en` SHALL hold one-hot(set) from ALLOC through TAG_O and SHALL be 0 in IDLE.
REQ-030 All strobes, way selects and enables SHALL be 0 whenever they are not asserted as stated above.

Reset
REQ-031 `rst` low SHALL immediately force IDLE, clear all counters and latches, and drive every output to 0.
REQ-032 Reset mid-fill SHALL abandon the fill with no tag write, so a partially filled block is never marked valid; the first `miss` after reset SHALL start a complete fill.

Configuration
REQ-033 With `FILL_CRITICAL_WORD_FIRST_EN` defined, the start word SHALL be `miss_addr`[3:1], and issue/receive SHALL wrap 7->0.
REQ-034 Without `FILL_CRITICAL_WORD_FIRST_EN`, the start word SHALL be 0 and the order SHALL be 0..7.

Verification
REQ-035 Scenario 1 (4-cycle memory model, `mem_data_out` = address): both ways invalid, miss 0x1234 -> way0 filled, set 0x23, words 0..7 written with data 0x1230..0x123E, then `Tag_In` 0x44 to way0 and 0x80 to way1, `fill_done` at cycle 15.
REQ-036 Scenario 2: way0 valid and MRU, way1 valid and LRU (`tag_out1`[7] = 1) -> victim way1, TAG_V writes way1 with {0, 1, tag}, TAG_O writes way0 with LRU = 1.
REQ-037 Scenario 3 (`FILL_CRITICAL_WORD_FIRST_EN`): miss 0x00AC -> `mem_addr` sequence 0x00AC, AE, A0, A2, A4, A6, A8, AA, with `word_enable` 0x40, 0x80, 0x01, ... 0x20.
REQ-038 Scenario 4: `rst` low during the 5th data write -> all outputs 0 next cycle with no `tag_wrt_en` pulse; a following miss completes normally.
REQ-039 Scenario 5: `miss` held high through the fill plus a stray `mem_data_valid` in IDLE and after the 8th word -> exactly 8 data writes, 2 tag writes and 1 `fill_done`.

Source files
------------

// File: rtl/icache_fill_ctrl.sv
// rtl/icache_fill_ctrl.sv - 2-way icache line fill controller (option: FILL_CRITICAL_WORD_FIRST_EN)
module icache_fill_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss,
    input  logic [15:0] miss_addr,
    input  logic [7:0]  tag_out0,
    input  logic [7:0]  tag_out1,
    input  logic [15:0] mem_data_out,
    input  logic        mem_data_valid,
    output logic [15:0] mem_addr,
    output logic        mem_enable,
    output logic        data_wrt_en,
    output logic        tag_wrt_en,
    output logic        way0,
    output logic        way1,
    output logic [7:0]  Tag_In,
    output logic [15:0] Data_In,
    output logic [63:0] blk_en,
    output logic [7:0]  word_enable,
    output logic        busy,
    output logic        fill_done
);

    typedef enum logic [2:0] {IDLE, ALLOC, FILL, TAG_V, TAG_O} state_t;

    state_t      state, state_nxt;
    logic [5:0]  tag_q, set_q, oth_tag_q;
    logic [2:0]  start_q;
    logic        victim_q, oth_valid_q;
    logic [3:0]  iss_cnt, rcv_cnt;
    logic        victim_sel, issue, rcv_fire;
    logic [2:0]  iss_word, rcv_word, start_sel;
    logic        unused_bits;

    assign unused_bits = &{1'b0, miss_addr[3:0], tag_out1[7]};

`ifdef FILL_CRITICAL_WORD_FIRST_EN
    assign start_sel = miss_addr[3:1];
`else
    assign start_sel = 3'd0;
`endif

    // Prefer an invalid way; with both valid, evict whichever carries the LRU bit.
    assign victim_sel = !tag_out0[6] ? 1'b0 :
                        !tag_out1[6] ? 1'b1 :
                        tag_out0[7]  ? 1'b0 : 1'b1;

    assign issue    = (state == FILL) && !iss_cnt[3];
    assign rcv_fire = (state == FILL) && mem_data_valid && !rcv_cnt[3];
    assign iss_word = start_q + iss_cnt[2:0];
    assign rcv_word = start_q + rcv_cnt[2:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tag_q       <= '0;
            set_q       <= '0;
            start_q     <= '0;
            victim_q    <= 1'b0;
            oth_valid_q <= 1'b0;
            oth_tag_q   <= '0;
            iss_cnt     <= '0;
            rcv_cnt     <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && miss) begin
                tag_q   <= miss_addr[15:10];
                set_q   <= miss_addr[9:4];
                start_q <= start_sel;
                iss_cnt <= '0;
                rcv_cnt <= '0;
            end
            if (state == ALLOC) begin
                victim_q    <= victim_sel;
                oth_valid_q <= victim_sel ? tag_out0[6]   : tag_out1[6];
                oth_tag_q   <= victim_sel ? tag_out0[5:0] : tag_out1[5:0];
            end
            if (issue)
                iss_cnt <= iss_cnt + 4'd1;
            if (rcv_fire)
                rcv_cnt <= rcv_cnt + 4'd1;
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_addr    = '0;
        mem_enable  = 1'b0;
        data_wrt_en = 1'b0;
        tag_wrt_en  = 1'b0;
        way0        = 1'b0;
        way1        = 1'b0;
        Tag_In      = '0;
        Data_In     = '0;
        blk_en      = '0;
        word_enable = '0;
        busy        = 1'b1;
        fill_done   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (miss)
                    state_nxt = ALLOC;
            end
            ALLOC: begin
                blk_en    = 64'd1 << set_q;
                state_nxt = FILL;
            end
            FILL: begin
                blk_en = 64'd1 << set_q;
                if (issue) begin
                    mem_enable = 1'b1;
                    mem_addr   = {tag_q, set_q, iss_word, 1'b0};
                end
                if (rcv_fire) begin
                    data_wrt_en = 1'b1;
                    way0        = !victim_q;
                    way1        = victim_q;
                    word_enable = 8'd1 << rcv_word;
                    Data_In     = mem_data_out;
                    if (rcv_cnt == 4'd7)
                        state_nxt = TAG_V;
                end
            end
            TAG_V: begin
                blk_en     = 64'd1 << set_q;
                tag_wrt_en = 1'b1;
                way0       = !victim_q;
                way1       = victim_q;
                Tag_In     = {1'b0, 1'b1, tag_q};
                state_nxt  = TAG_O;
            end
            TAG_O: begin
                blk_en     = 64'd1 << set_q;
                tag_wrt_en = 1'b1;
                way0       = victim_q;
                way1       = !victim_q;
                Tag_In     = {1'b1, oth_valid_q, oth_tag_q};
                fill_done  = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
